// File: rtl/sfp_accum.sv
// Partial-sum accumulator behind the output SRAM read port: sums num_k partial-sum vectors
// per output pixel in a register buffer, then drains the totals (optionally ReLU'd) on a stream.
module sfp_accum #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 2,
  parameter int unsigned depth   = 16,
  parameter int unsigned kw      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(depth+1)-1:0]   num_o,
  input  logic [kw-1:0]                num_k,
  input  logic                         relu_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [psum_bw*col-1:0]       in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [psum_bw*col-1:0]       out_data,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned OW = $clog2(depth + 1);
  localparam int unsigned IW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned DW = psum_bw * col;

  typedef enum logic [1:0] {StIdle, StAcc, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   num_o_q, num_o_d, o_idx_q, o_idx_d, rd_idx_q, rd_idx_d, num_o_clamped;
  logic [kw-1:0]   num_k_q, num_k_d, k_idx_q, k_idx_d;
  logic            relu_q, relu_d;
  logic            buf_we;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   buf_q [depth];
  logic [psum_bw-1:0] acc_lane, in_lane, rd_lane;

  assign num_o_clamped = (num_o > OW'(depth)) ? OW'(depth) : num_o;
  assign busy          = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    num_o_d   = num_o_q;
    num_k_d   = num_k_q;
    relu_d    = relu_q;
    o_idx_d   = o_idx_q;
    k_idx_d   = k_idx_q;
    rd_idx_d  = rd_idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    buf_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_o_d  = num_o_clamped;
          num_k_d  = num_k;
          relu_d   = relu_en;
          o_idx_d  = '0;
          k_idx_d  = '0;
          rd_idx_d = '0;
          state_d  = (num_o_clamped == '0 || num_k == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we = 1'b1;
          if (o_idx_q == num_o_q - OW'(1)) begin
            o_idx_d = '0;
            if (k_idx_q == num_k_q - kw'(1)) begin
              rd_idx_d = '0;
              state_d  = StDrain;
            end else begin
              k_idx_d = k_idx_q + kw'(1);
            end
          end else begin
            o_idx_d = o_idx_q + OW'(1);
          end
        end
      end
      StDrain: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (rd_idx_q == num_o_q - OW'(1)) begin
            state_d = StDone;
          end else begin
            rd_idx_d = rd_idx_q + OW'(1);
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // First kernel position overwrites, so stale buffer contents never reach the output.
  always_comb begin
    wr_data  = '0;
    out_data = '0;
    acc_lane = '0;
    in_lane  = '0;
    rd_lane  = '0;
    for (int unsigned i = 0; i < col; i++) begin
      acc_lane = buf_q[o_idx_q[IW-1:0]][i*psum_bw +: psum_bw];
      in_lane  = in_data[i*psum_bw +: psum_bw];
      wr_data[i*psum_bw +: psum_bw] = (k_idx_q == '0) ? in_lane : acc_lane + in_lane;
      rd_lane  = buf_q[rd_idx_q[IW-1:0]][i*psum_bw +: psum_bw];
      if (state_q == StDrain) begin
        out_data[i*psum_bw +: psum_bw] = (relu_q && rd_lane[psum_bw-1]) ? '0 : rd_lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      num_o_q  <= '0;
      num_k_q  <= '0;
      relu_q   <= 1'b0;
      o_idx_q  <= '0;
      k_idx_q  <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      num_o_q  <= num_o_d;
      num_k_q  <= num_k_d;
      relu_q   <= relu_d;
      o_idx_q  <= o_idx_d;
      k_idx_q  <= k_idx_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[o_idx_q[IW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sfp_accum.sv
// Scoreboard bench for sfp_accum: stimulus pushes expected drain vectors, a negedge monitor
// pops and compares them on every presented output.
module tb_sfp_accum;
  localparam int OW = 5;
  localparam int KW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, relu_en = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b1;
  logic [OW-1:0] num_o = '0;
  logic [KW-1:0] num_k = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, busy, done;
  logic [DW-1:0] out_data;

  sfp_accum #(.psum_bw(16), .col(2), .depth(16), .kw(4)) dut (
    .clk(clk), .reset(reset), .start(start), .num_o(num_o), .num_k(num_k),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, cyc_start = 0, done_cnt = 0, dc0 = 0;
  logic [DW-1:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mk(input int l1, input int l0);
    return {l1[15:0], l0[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented output against the scoreboard head, stalls included.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got 0x%0h, want no output", out_data);
        end else begin
          check("out_data", out_data, sb[0]);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input int no, input int nk, input logic relu);
    num_o     = no[OW-1:0];
    num_k     = nk[KW-1:0];
    relu_en   = relu;
    start     = 1'b1;
    cyc_start = cyc;
    dc0       = done_cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_cycles"}, cyc - cyc_start, exp_cycles);
    tick();
    check({name, "_busy_low"}, busy, 0);
    check({name, "_done_once"}, done_cnt - dc0, 1);
  endtask

  initial begin
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // Basic accumulate, also measures start-to-first-output latency.
    sb.push_back(mk(111, 222));
    sb.push_back(mk(333, 444));
    start_pass(2, 3, 1'b0);
    check("acc_in_ready", in_ready, 1);
    send(mk(1, 2));     send(mk(3, 4));
    send(mk(10, 20));   send(mk(30, 40));
    send(mk(100, 200)); send(mk(300, 400));
    check("lat_out_valid", out_valid, 1);
    check("lat_cycles", cyc - cyc_start, 7);
    wait_done("basic", 9);

    // ReLU and sign handling.
    sb.push_back(32'h0);
    start_pass(1, 2, 1'b1);
    send(mk(5, -3)); send(mk(-10, 1));
    wait_done("relu_on", 4);
    sb.push_back(32'hFFFB_FFFE);
    start_pass(1, 2, 1'b0);
    send(mk(5, -3)); send(mk(-10, 1));
    wait_done("relu_off", 4);

    // Signed wrap without saturation.
    sb.push_back(32'h0000_8000);
    start_pass(1, 2, 1'b0);
    send(mk(0, 32'h7FFF)); send(mk(0, 1));
    wait_done("wrap", 4);
    sb.push_back(32'h0);
    start_pass(1, 2, 1'b1);
    send(mk(0, 32'h7FFF)); send(mk(0, 1));
    wait_done("wrap_relu", 4);

    // Backpressure with in_valid junk pulsed during every stall.
    for (int i = 0; i < 4; i++) sb.push_back(mk(i + 1, 50 * (i + 1)));
    start_pass(4, 1, 1'b0);
    for (int i = 0; i < 4; i++) send(mk(i + 1, 50 * (i + 1)));
    for (int i = 0; i < 40 && !done; i++) begin
      out_ready = ((i % 3) == 1);
      in_valid  = !out_ready;
      in_data   = 32'hDEAD_BEEF;
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("bp_sb_empty_at_done", sb.size(), 0);
    wait_done("bp", 16);

    // Degenerate pass: no kernel positions.
    start_pass(3, 0, 1'b0);
    check("degen_in_ready", in_ready, 0);
    check("degen_out_valid", out_valid, 0);
    wait_done("degen", 1);

    // num_o above depth clamps to depth entries.
    for (int i = 0; i < 16; i++) sb.push_back(mk(i, 100 + i));
    start_pass(21, 1, 1'b0);
    for (int i = 0; i < 16; i++) send(mk(i, 100 + i));
    check("clamp_in_ready", in_ready, 0);
    check("clamp_out_valid", out_valid, 1);
    wait_done("clamp", 33);

    // Reset mid-pass, then a fresh pass must not see stale data.
    start_pass(4, 2, 1'b0);
    send(mk(900, 901)); send(mk(902, 903)); send(mk(904, 905));
    reset = 1'b1;
    tick();
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    tick();
    sb.push_back(mk(7, 8));
    start_pass(1, 1, 1'b0);
    send(mk(7, 8));
    wait_done("post_rst", 3);

    tick();
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
